sfu_multibank: RTL and testbench
================================

Name: sfu_multibank

Overview:
- Parametrised successor to the single-accumulator SFU, sitting between the MAC array column outputs and the output SRAM write path.
- Holds `depth` independent accumulation slots; each slot has `col` lanes of signed `acc_bw` accumulators.
- Each incoming psum vector is added into, or overwrites, an addressed slot, with per-lane saturation.
- Slots are read out with one-cycle latency, optional ReLU, and narrowing saturation to `psum_bw`.

Parameters:
- col, 8, number of lanes (array columns)
- psum_bw, 16, signed width of each input/output lane
- acc_bw, 20, signed accumulator width per lane; must be >= psum_bw
- depth, 4, number of accumulation slots; power of two, >= 2
- aw, $clog2(depth), slot address width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- acc_i  in  1  accumulate strobe; psum_in is consumed this cycle
- clr_i  in  1  with acc_i: overwrite the slot instead of adding to it
- wr_addr_i  in  aw  slot targeted by acc_i
- psum_in  in  psum_bw*col  signed lanes; lane c at bits [psum_bw*c +: psum_bw]
- rd_i  in  1  read request
- rd_addr_i  in  aw  slot to read
- relu_en_i  in  1  apply ReLU on readout (sampled with rd_i)
- valid_o  out  1  psum_out valid, one cycle after rd_i
- psum_out  out  psum_bw*col  read result, same lane packing as psum_in

Behaviour:
- Reset (reset==0 at a clk edge):
  - all slots and lanes are cleared to 0;
  - valid_o=0 and psum_out=0;
  - ovf_o=0 when the optional feature is compiled in.
  - reset overrides acc_i and rd_i in the same cycle.
  - Mid-operation reset discards all accumulated data; the first cycle after reset deasserts accepts traffic normally.
- Accumulate (acc_i=1):
  - each lane is sign-extended from psum_bw to acc_bw.
  - clr_i=1: slot[wr_addr_i][c] <= sext(psum_c).
  - clr_i=0: slot[wr_addr_i][c] <= sat_acc(slot + sext(psum_c)).
  - The sum is computed at acc_bw+1 bits, then clamped to [-2^(acc_bw-1), 2^(acc_bw-1)-1].
  - Lanes saturate independently.
  - The update is visible on the next cycle; back-to-back acc_i to the same slot chains correctly with no bubbles.
- clr_i while acc_i=0 is ignored.
- Read (rd_i=1):
  - on the next cycle valid_o=1 and psum_out holds the lanes of slot[rd_addr_i] as sampled at the rd_i edge.
  - Each lane is processed in order: first ReLU when relu_en_i=1 (negative -> 0), then sat_out, which clamps the acc_bw value to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - With rd_i=0, valid_o=0 next cycle and psum_out holds its last value.
- Read is non-destructive; slot contents are unchanged.
- Simultaneous acc_i and rd_i:
  - same slot: the read returns the pre-update value (read-before-write), and the update still commits.
  - different slots: fully independent.
- Throughput is one accumulate plus one read per cycle, sustained.
- Latency: accumulate-to-readable is 1 cycle; rd_i-to-valid_o is 1 cycle.
- Address wrap: wr_addr_i and rd_addr_i are exactly aw bits, so there are no out-of-range slots.

Optional Feature:
- Macro: SFU_OVF_STICKY_EN.
- Defined:
  - adds output ovf_o (1 bit).
  - ovf_o sets to 1 on any cycle where any lane saturates in sat_acc, or where a lane saturates in sat_out during a read.
  - ovf_o stays set until reset.
  - ovf_o resets to 0.
- Undefined:
  - port ovf_o is absent.
  - saturation behaviour is identical; no overflow status is kept.

Test Plan:
1. Reset hold: reset=0 for 2 cycles with acc_i=1, psum lanes=0x0005 -> after release, rd_i on slot 0 gives valid_o=1 next cycle and all lanes 0x0000.
2. Accumulate chain: slot 2, clr_i=1 with lanes=0x0003, then 3 cycles of clr_i=0 with lanes=0xFFFF (-1) -> read slot 2 gives all lanes 0x0000; read slots 0, 1, 3 give 0.
3. ReLU/narrowing: slot 1 loaded with lane0=-7 (0xFFF9) and lane1=0x7FFF, then added with lane1=0x7FFF (acc=65534) -> read with relu_en_i=1 gives lane0=0x0000 and lane1=0x7FFF (clamped); with relu_en_i=0 it gives lane0=0xFFF9.
4. Accumulator saturation: acc_bw=20; add 0x7FFF to slot 0 40 times (sum 1,310,680 > 524,287) -> internal lane pinned at 524287; readout 0x7FFF; ovf_o=1 if SFU_OVF_STICKY_EN.
5. Same-slot collision: slot 3 holds 10; acc_i (add 5) and rd_i both on slot 3 in the same cycle -> psum_out=10; a read the next cycle gives 15.
6. Mid-operation reset: slots 0-3 hold non-zero values; assert reset=0 for one cycle during an active acc_i/rd_i stream -> valid_o=0 the next cycle, all slots read back 0, ovf_o=0.

Source files
------------

// File: rtl/sfu_multibank.sv
// sfu_multibank: multi-slot saturating psum accumulator between the MAC array
// columns and the output SRAM write path. Each slot holds `col` signed acc_bw
// lanes; readout applies optional ReLU and narrows to psum_bw with saturation.
// Optional feature macro: SFU_OVF_STICKY_EN adds a sticky overflow flag ovf_o.
module sfu_multibank #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned acc_bw  = 20,
  parameter int unsigned depth   = 4,
  localparam int unsigned aw     = $clog2(depth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_i,
  input  logic                     clr_i,
  input  logic [aw-1:0]            wr_addr_i,
  input  logic [psum_bw*col-1:0]   psum_in,
  input  logic                     rd_i,
  input  logic [aw-1:0]            rd_addr_i,
  input  logic                     relu_en_i,
  output logic                     valid_o,
  output logic [psum_bw*col-1:0]   psum_out
`ifdef SFU_OVF_STICKY_EN
  ,
  output logic                     ovf_o
`endif
);

  localparam logic [acc_bw-1:0]  ACC_MAX = {1'b0, {(acc_bw-1){1'b1}}};
  localparam logic [acc_bw-1:0]  ACC_MIN = {1'b1, {(acc_bw-1){1'b0}}};
  localparam logic [psum_bw-1:0] OUT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] OUT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [acc_bw-1:0]  r_slot [depth][col];
  logic                      r_valid;
  logic [psum_bw*col-1:0]    r_psum_out;

  logic signed [acc_bw-1:0]  w_ext     [col];
  logic signed [acc_bw:0]    w_sum     [col];
  logic                      w_sat_acc [col];
  logic signed [acc_bw-1:0]  w_acc_nxt [col];
  logic signed [acc_bw-1:0]  w_rv      [col];
  logic [acc_bw-psum_bw:0]   w_hi      [col];
  logic                      w_sat_out [col];
  logic [psum_bw-1:0]        w_out_nxt [col];

  // Per-lane accumulate path (widened add + clamp) and readout path (ReLU + narrow)
  always_comb begin
    for (int c = 0; c < int'(col); c++) begin
      w_ext[c]     = acc_bw'($signed(psum_in[psum_bw*c +: psum_bw]));
      w_sum[c]     = (acc_bw+1)'(r_slot[wr_addr_i][c]) + (acc_bw+1)'(w_ext[c]);
      w_sat_acc[c] = w_sum[c][acc_bw] ^ w_sum[c][acc_bw-1];
      if (clr_i) begin
        w_acc_nxt[c] = w_ext[c];
      end else if (w_sat_acc[c]) begin
        w_acc_nxt[c] = w_sum[c][acc_bw] ? ACC_MIN : ACC_MAX;
      end else begin
        w_acc_nxt[c] = w_sum[c][acc_bw-1:0];
      end

      w_rv[c] = r_slot[rd_addr_i][c];
      if (relu_en_i && w_rv[c][acc_bw-1]) begin
        w_rv[c] = '0;
      end
      // Value fits psum_bw only when all bits from the output sign upward agree
      w_hi[c]      = w_rv[c][acc_bw-1:psum_bw-1];
      w_sat_out[c] = ~((&w_hi[c]) | ~(|w_hi[c]));
      if (w_sat_out[c]) begin
        w_out_nxt[c] = w_rv[c][acc_bw-1] ? OUT_MIN : OUT_MAX;
      end else begin
        w_out_nxt[c] = w_rv[c][psum_bw-1:0];
      end
    end
  end

`ifdef SFU_OVF_STICKY_EN
  logic w_any_acc_sat;
  logic w_any_out_sat;
  logic r_ovf;

  // Any-lane saturation detect; clr_i overwrites cannot overflow
  always_comb begin
    w_any_acc_sat = 1'b0;
    w_any_out_sat = 1'b0;
    for (int c = 0; c < int'(col); c++) begin
      w_any_acc_sat = w_any_acc_sat | w_sat_acc[c];
      w_any_out_sat = w_any_out_sat | w_sat_out[c];
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if ((acc_i && !clr_i && w_any_acc_sat) || (rd_i && w_any_out_sat)) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`endif

  // Slot storage and registered readout; read sees pre-update slot contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < int'(depth); d++) begin
        for (int c = 0; c < int'(col); c++) begin
          r_slot[d][c] <= '0;
        end
      end
      r_valid    <= 1'b0;
      r_psum_out <= '0;
    end else begin
      if (acc_i) begin
        for (int c = 0; c < int'(col); c++) begin
          r_slot[wr_addr_i][c] <= w_acc_nxt[c];
        end
      end
      r_valid <= rd_i;
      if (rd_i) begin
        for (int c = 0; c < int'(col); c++) begin
          r_psum_out[psum_bw*c +: psum_bw] <= w_out_nxt[c];
        end
      end
    end
  end

  assign valid_o  = r_valid;
  assign psum_out = r_psum_out;

endmodule

// File: tb/tb_sfu_multibank.sv
// Scoreboard bench for sfu_multibank: the driver pushes one expectation per
// clock edge from a plain-arithmetic slot model; the monitor pops and compares.
module tb_sfu_multibank;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int ABW   = 20;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = PBW * COL;

  localparam longint ACC_MAX = (longint'(1) << (ABW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ABW - 1));
  localparam longint OUT_MAX = (longint'(1) << (PBW - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) << (PBW - 1));

  bit              clk;
  logic            reset;
  logic            acc_i;
  logic            clr_i;
  logic [AW-1:0]   wr_addr_i;
  logic [W-1:0]    psum_in;
  logic            rd_i;
  logic [AW-1:0]   rd_addr_i;
  logic            relu_en_i;
  logic            valid_o;
  logic [W-1:0]    psum_out;
`ifdef SFU_OVF_STICKY_EN
  logic            ovf_o;
`endif

  sfu_multibank #(.col(COL), .psum_bw(PBW), .acc_bw(ABW), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .acc_i     (acc_i),
    .clr_i     (clr_i),
    .wr_addr_i (wr_addr_i),
    .psum_in   (psum_in),
    .rd_i      (rd_i),
    .rd_addr_i (rd_addr_i),
    .relu_en_i (relu_en_i),
    .valid_o   (valid_o),
    .psum_out  (psum_out)
`ifdef SFU_OVF_STICKY_EN
    ,
    .ovf_o     (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           ovf;
  } exp_t;

  exp_t         q[$];
  longint       model [DEPTH][COL];
  logic [W-1:0] m_last;
  bit           m_ovf;
  bit           running;
  int           total;
  int           bad;

  function automatic longint lane_of(input logic [W-1:0] p, input int c);
    logic [PBW-1:0] s;
    s = p[PBW*c +: PBW];
    return longint'($signed(s));
  endfunction

  function automatic logic [W-1:0] all_lanes(input logic [PBW-1:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[PBW*c +: PBW] = v;
    return r;
  endfunction

  // Model one clock edge and queue the response the DUT must show after it
  task automatic step(input bit rst, input bit acc, input bit clr, input int wa,
                      input logic [W-1:0] p, input bit rd, input int ra, input bit relu);
    exp_t e;
    reset     = rst;
    acc_i     = acc;
    clr_i     = clr;
    wr_addr_i = AW'(wa);
    psum_in   = p;
    rd_i      = rd;
    rd_addr_i = AW'(ra);
    relu_en_i = relu;
    if (!rst) begin
      for (int d = 0; d < DEPTH; d++)
        for (int c = 0; c < COL; c++) model[d][c] = 0;
      m_last = '0;
      m_ovf  = 1'b0;
      e.v    = 1'b0;
    end else begin
      e.v = rd;
      if (rd) begin
        for (int c = 0; c < COL; c++) begin
          longint v;
          v = model[ra][c];
          if (relu && v < 0) v = 0;
          if (v > OUT_MAX) begin v = OUT_MAX; m_ovf = 1'b1; end
          if (v < OUT_MIN) begin v = OUT_MIN; m_ovf = 1'b1; end
          m_last[PBW*c +: PBW] = PBW'(v);
        end
      end
      if (acc) begin
        for (int c = 0; c < COL; c++) begin
          longint s;
          if (clr) s = lane_of(p, c);
          else     s = model[wa][c] + lane_of(p, c);
          if (s > ACC_MAX) begin s = ACC_MAX; m_ovf = 1'b1; end
          if (s < ACC_MIN) begin s = ACC_MIN; m_ovf = 1'b1; end
          model[wa][c] = s;
        end
      end
    end
    e.d   = m_last;
    e.ovf = m_ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int a, input bit relu);
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, a, relu);
  endtask

  task automatic acc(input int a, input bit clr, input logic [W-1:0] p);
    step(1'b1, 1'b1, clr, a, p, 1'b0, 0, 1'b0);
  endtask

  function automatic logic [PBW-1:0] rand_lane();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return PBW'($urandom_range(0, 15)) - 16'd8;
      default: return PBW'($urandom);
    endcase
  endfunction

  // Monitor: compare DUT outputs against the queued expectation after each edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (valid_o !== e.v) begin
          bad++;
          $display("FAIL valid_o t=%0t got=%b want=%b", $time, valid_o, e.v);
        end
        total++;
        if (psum_out !== e.d) begin
          bad++;
          $display("FAIL psum_out t=%0t got=%h want=%h", $time, psum_out, e.d);
        end
`ifdef SFU_OVF_STICKY_EN
        total++;
        if (ovf_o !== e.ovf) begin
          bad++;
          $display("FAIL ovf_o t=%0t got=%b want=%b", $time, ovf_o, e.ovf);
        end
`endif
      end else if (running) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow t=%0t got=empty want=entry", $time);
      end
    end
  end

  initial begin
    logic [W-1:0] p;
    running = 1'b1;
    total   = 0;
    bad     = 0;

    // 1. reset held with acc active, then slot 0 reads zero
    step(1'b0, 1'b1, 1'b0, 0, all_lanes(16'h0005), 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, all_lanes(16'h0005), 1'b0, 0, 1'b0);
    rd(0, 1'b0);
    idle();

    // 2. accumulate chain on slot 2 back to zero; other slots untouched
    acc(2, 1'b1, all_lanes(16'h0003));
    for (int i = 0; i < 3; i++) acc(2, 1'b0, all_lanes(16'hFFFF));
    rd(2, 1'b0); rd(0, 1'b0); rd(1, 1'b0); rd(3, 1'b0);

    // 3. ReLU and output narrowing on slot 1
    p = '0; p[15:0] = 16'hFFF9; p[31:16] = 16'h7FFF;
    acc(1, 1'b1, p);
    p = '0; p[31:16] = 16'h7FFF;
    acc(1, 1'b0, p);
    rd(1, 1'b1);
    rd(1, 1'b0);

    // 4. accumulator saturation on slot 0
    for (int i = 0; i < 40; i++) acc(0, 1'b0, all_lanes(16'h7FFF));
    rd(0, 1'b0);
    rd(0, 1'b1);

    // 5. same-slot read/accumulate collision
    acc(3, 1'b1, all_lanes(16'd10));
    step(1'b1, 1'b1, 1'b0, 3, all_lanes(16'd5), 1'b1, 3, 1'b0);
    rd(3, 1'b0);

    // 6. mid-stream reset wipes everything
    for (int a = 0; a < DEPTH; a++) acc(a, 1'b1, all_lanes(PBW'(a + 100)));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, i, all_lanes(16'h0011), 1'b1, (i + 1) % DEPTH, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1, all_lanes(16'h0022), 1'b1, 2, 1'b0);
    for (int a = 0; a < DEPTH; a++) rd(a, 1'b0);

    // Randomized mixed traffic, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < COL; c++) p[PBW*c +: PBW] = rand_lane();
      step(($urandom_range(0, 299) != 0), 1'(($urandom_range(0, 3)) != 0),
           1'(($urandom_range(0, 7)) == 0), int'($urandom_range(0, DEPTH - 1)), p,
           1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           1'($urandom_range(0, 1)));
    end
    for (int a = 0; a < DEPTH; a++) rd(a, 1'b0);
    idle();

    running = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
